ipsxe_floating_point_invsqrt_rne_pack_v1_0: RTL
===============================================

// Module: ipsxe_floating_point_invsqrt_rne_pack_v1_0
// PURPOSE
//   Downstream consumer of the group3 round stage of the inverse-square-root datapath.
//   - Takes the rounded mantissa (truncated + guard, i.e. round-half-up from the APM post-adder)
//     plus the guard/sticky bits.
//   - Applies the ties-to-even correction, renormalises on rounding carry and updates the exponent.
//   - Muxes in special results and packs an IEEE-754 word.
//   - Two-stage valid/ready pipeline with full backpressure.
// PARAMETERS
//   MAN_WIDTH  52  fraction width (hidden bit excluded)
//   EXP_WIDTH  11  exponent width; max normal exponent = 2^EXP_WIDTH-2
// PORTS
//   i_clk        in   1                  clock, all state on rising edge
//   i_rst        in   1                  synchronous reset, active high
//   i_valid      in   1                  input beat valid
//   o_ready      out  1                  block can accept input this cycle
//   i_group3     in   MAN_WIDTH+2        rounded mantissa: [MAN_WIDTH+1]=carry, [MAN_WIDTH]=hidden
//   i_guard      in   1                  guard bit used by the upstream round (bit RNE-1)
//   i_sticky     in   1                  OR of all bits below the guard
//   i_exp        in   EXP_WIDTH          biased result exponent before carry adjust
//   i_nan        in   1                  operand NaN or negative non-zero -> qNaN
//   i_inf_res    in   1                  operand +/-0 -> +inf
//   i_zero_res   in   1                  operand +inf -> +0
//   o_valid      out  1                  output beat valid
//   i_ready      in   1                  downstream accepts output
//   o_result     out  EXP_WIDTH+MAN_WIDTH+1  packed result {sign,exp,frac}
// BEHAVIOUR
//   Reset: s1_valid=0, s2_valid=0, so o_valid=0 the cycle after i_rst is sampled high.
//     o_result=0 at reset. In-flight beats are discarded (reset mid-stall included).
//     o_ready=1 from the first cycle after reset.
//   Handshake:
//     - Input transfer when i_valid&o_ready; output transfer when o_valid&i_ready.
//     - s2 loads when ~s2_valid|i_ready; s1 loads when ~s1_valid|s2 load.
//     - o_ready = ~s1_valid | s2_load (combinational, no dependence on i_valid).
//     - Data and o_valid hold stable while o_valid&~i_ready.
//     - No bubbles when i_ready=1: one beat per cycle, latency 2 cycles (accept at n, o_valid at n+2).
//     - Beat order preserved; no loss or duplication under any i_ready pattern.
//   Stage 1 (rounding fix):
//     - tie = i_guard & ~i_sticky. If tie, force mantissa LSB (bit0) to 0.
//       Upstream produced Z+1; clearing the LSB yields round-to-even.
//     - carry = i_group3[MAN_WIDTH+1].
//     - Register: mant[MAN_WIDTH+1:0], exp, carry, special flags.
//   Stage 2 (normalise + pack):
//     - carry=1: frac=0, exp_out=exp+1 (value is exactly a power of two).
//     - carry=0: frac=mant[MAN_WIDTH-1:0], exp_out=exp.
//     - exp_out = 2^EXP_WIDTH-1 (overflow, computed in EXP_WIDTH+1 bits) -> +inf.
//     - Special priority: i_nan > i_inf_res > i_zero_res > normal.
//       NaN = {0, all-1 exp, 1, 0...}; inf = {0, all-1, 0}; zero = all 0.
//     - Specials ignore mantissa, guard and sticky.
//     - Sign bit is always 0 (invsqrt result is non-negative or NaN).
//   Simultaneous accept on input and output in one cycle is legal and must not drop a beat.
// TESTING (MAN_WIDTH=52, EXP_WIDTH=11)
//   1. mant=54'h10_0000_0000_0001, guard=1, sticky=1, exp=1023
//      -> o_result=64'h3FF0_0000_0000_0001, 2 cycles after accept.
//   2. mant=54'h10_0000_0000_0003, guard=1, sticky=0 (tie)
//      -> LSB cleared, o_result=64'h3FF0_0000_0000_0002.
//   3. mant=54'h20_0000_0000_0000 (carry), exp=1023 -> o_result=64'h4000_0000_0000_0000.
//   4. carry with exp=2046 -> 64'h7FF0_0000_0000_0000.
//      Separately: i_nan -> 64'h7FF8_0000_0000_0000; i_inf_res -> 64'h7FF0...; i_zero_res -> 64'h0.
//   5. Stream 4 beats with i_ready=0 for 3 cycles -> o_ready falls after 2 beats held.
//      All 4 beats emerge in order once i_ready=1; o_result stable while stalled.
//   6. Assert i_rst during a stall with both stages full
//      -> o_valid=0 next cycle, o_ready=1; held beats are never output.

Source files
------------

// File: rtl/ipsxe_floating_point_invsqrt_rne_pack_v1_0.sv
// Final stage of the inverse-square-root datapath: ties-to-even fix on the upstream
// round-half-up mantissa, carry renormalisation, special-value muxing and IEEE-754 packing.
module ipsxe_floating_point_invsqrt_rne_pack_v1_0 #(
  parameter int MAN_WIDTH = 52,
  parameter int EXP_WIDTH = 11
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_valid,
  output logic                           o_ready,
  input  logic [MAN_WIDTH+1:0]           i_group3,
  input  logic                           i_guard,
  input  logic                           i_sticky,
  input  logic [EXP_WIDTH-1:0]           i_exp,
  input  logic                           i_nan,
  input  logic                           i_inf_res,
  input  logic                           i_zero_res,
  output logic                           o_valid,
  input  logic                           i_ready,
  output logic [EXP_WIDTH+MAN_WIDTH:0]   o_result
);

  localparam int RES_WIDTH = EXP_WIDTH + MAN_WIDTH + 1;
  localparam logic [EXP_WIDTH:0] EXP_ALL_ONES = {1'b0, {EXP_WIDTH{1'b1}}};

  localparam logic [RES_WIDTH-1:0] QNAN_WORD =
    {1'b0, {EXP_WIDTH{1'b1}}, 1'b1, {(MAN_WIDTH-1){1'b0}}};
  localparam logic [RES_WIDTH-1:0] INF_WORD =
    {1'b0, {EXP_WIDTH{1'b1}}, {MAN_WIDTH{1'b0}}};

  logic                 s1_valid;
  logic                 s2_valid;
  logic                 s1_load;
  logic                 s2_load;

  logic [MAN_WIDTH-1:0] s1_frac;
  logic                 s1_carry;
  logic [EXP_WIDTH-1:0] s1_exp;
  logic                 s1_nan;
  logic                 s1_inf;
  logic                 s1_zero;

  logic                 tie;
  logic [MAN_WIDTH-1:0] frac_fix;

  logic [EXP_WIDTH:0]   exp_sum;
  logic [MAN_WIDTH-1:0] frac_out;
  logic [RES_WIDTH-1:0] result_next;
  logic [RES_WIDTH-1:0] s2_result;

  // The hidden bit is implied by the packed format and never needs to travel further.
  logic                 hidden_unused;
  assign hidden_unused = i_group3[MAN_WIDTH];

  // Each stage advances when it is empty or its consumer is taking its beat this cycle.
  assign s2_load  = ~s2_valid | i_ready;
  assign s1_load  = ~s1_valid | s2_load;
  assign o_ready  = s1_load;
  assign o_valid  = s2_valid;
  assign o_result = s2_result;

  // Upstream added half an ULP; on an exact tie that gives Z+1, and clearing bit 0 lands on the even neighbour.
  assign tie = i_guard & ~i_sticky;

  // NOTE: every variable driven in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    frac_fix = i_group3[MAN_WIDTH-1:0];
    if (tie) frac_fix[0] = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1_valid <= 1'b0;
    end else if (s1_load) begin
      s1_valid <= i_valid;
    end
  end

  // NOTE: pure datapath registers are not reset; the valid bits alone say whether they hold a beat.
  always_ff @(posedge i_clk) begin
    if (s1_load && i_valid) begin
      s1_frac  <= frac_fix;
      s1_carry <= i_group3[MAN_WIDTH+1];
      s1_exp   <= i_exp;
      s1_nan   <= i_nan;
      s1_inf   <= i_inf_res;
      s1_zero  <= i_zero_res;
    end
  end

  // A rounding carry means the mantissa is exactly 2.0, so the fraction collapses to zero.
  assign exp_sum  = {1'b0, s1_exp} + {{EXP_WIDTH{1'b0}}, s1_carry};
  assign frac_out = s1_carry ? '0 : s1_frac;

  always_comb begin
    result_next = {1'b0, exp_sum[EXP_WIDTH-1:0], frac_out};
    if (s1_nan) begin
      result_next = QNAN_WORD;
    end else if (s1_inf) begin
      result_next = INF_WORD;
    end else if (s1_zero) begin
      result_next = '0;
    end else if (exp_sum >= EXP_ALL_ONES) begin
      result_next = INF_WORD;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s2_valid  <= 1'b0;
      s2_result <= '0;
    end else if (s2_load) begin
      s2_valid <= s1_valid;
      if (s1_valid) s2_result <= result_next;
    end
  end

endmodule
